// File: rtl/obi_wb_pkg.sv
// Shared types for the OBI-to-Wishbone arbiter: FSM states, port owner, arbitration modes
// and the captured request record.
package obi_wb_pkg;

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
   typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;

   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;

   // Sized for the 32-bit cve2 buses; the top casts to its own parameter widths.
   localparam int unsigned OBI_ADDR_W = 32;
   localparam int unsigned OBI_DATA_W = 32;

   typedef struct packed {
      logic [OBI_ADDR_W-1:0]   addr;
      logic                    we;
      logic [OBI_DATA_W/8-1:0] be;
      logic [OBI_DATA_W-1:0]   wdata;
   } obi_req_t;

endpackage

// File: rtl/obi_rr_arbiter.sv
// Two-requester grant logic: combinational grant gated by en_i, with a last-winner pointer
// for round-robin (ARB_RR) or fixed data-first priority (ARB_FIXED).
module obi_rr_arbiter
   import obi_wb_pkg::*;
#(
   parameter int unsigned ARB_MODE = ARB_RR
) (
   input  logic clk_core,
   input  logic rst_core,
   input  logic en_i,
   input  logic req_instr_i,
   input  logic req_data_i,
   output logic gnt_instr_o,
   output logic gnt_data_o
);

   owner_e last_q, last_d;
   logic   pick_data;

   always_comb begin
      // On a tie, data wins unless it was the last port served in round-robin mode.
      pick_data   = req_data_i && (!req_instr_i || (ARB_MODE == ARB_FIXED) || (last_q == OWN_INSTR));
      gnt_data_o  = en_i && pick_data;
      gnt_instr_o = en_i && req_instr_i && !pick_data;
      last_d      = last_q;
      if (gnt_data_o) begin
         last_d = OWN_DATA;
      end else if (gnt_instr_o) begin
         last_d = OWN_INSTR;
      end
   end

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         last_q <= OWN_INSTR;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/obi_wb_arbiter.sv
// Shares one classic Wishbone port between cve2 instruction and data OBI ports, with a
// single outstanding access, pipelined re-grant in RESP and an optional ack timeout.
module obi_wb_arbiter
   import obi_wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ARB_MODE       = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk_core,
   input  logic                    rst_core,
   input  logic                    instr_req_i,
   output logic                    instr_gnt_o,
   output logic                    instr_rvalid_o,
   input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,
   output logic                    instr_err_o,
   input  logic                    data_req_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   output logic                    data_err_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic [ADDR_WIDTH-1:0]   wb_addr_o,
   output logic [DATA_WIDTH-1:0]   wb_data_o,
   input  logic [DATA_WIDTH-1:0]   wb_data_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i
);

   localparam int unsigned BE_W     = DATA_WIDTH / 8;
   localparam int unsigned OBI_BE_W = OBI_DATA_W / 8;
   localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

   state_e                state_q, state_d;
   owner_e                owner_q, owner_d;
   obi_req_t              req_q, req_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  grant_en, gnt_instr, gnt_data, tmo_hit;

   // A new access may be granted from IDLE or from RESP (pipelined turnaround).
   assign grant_en = !rst_core && (state_q != BUS);
   assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

   obi_rr_arbiter #(.ARB_MODE(ARB_MODE)) u_arb (
      .clk_core    (clk_core),
      .rst_core    (rst_core),
      .en_i        (grant_en),
      .req_instr_i (instr_req_i),
      .req_data_i  (data_req_i),
      .gnt_instr_o (gnt_instr),
      .gnt_data_o  (gnt_data)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      case (state_q)
         BUS: begin
            // An ack in the timeout cycle still completes normally.
            if (wb_ack_i || wb_err_i) begin
               rdata_d = req_q.we ? '0 : wb_data_i;
               err_d   = wb_err_i;
               state_d = RESP;
            end else if (tmo_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else if (tmo_q != '1) begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            if (gnt_data) begin
               owner_d     = OWN_DATA;
               req_d.addr  = OBI_ADDR_W'(data_addr_i);
               req_d.we    = data_we_i;
               req_d.be    = OBI_BE_W'(data_be_i);
               req_d.wdata = OBI_DATA_W'(data_wdata_i);
               tmo_d       = '0;
               state_d     = BUS;
            end else if (gnt_instr) begin
               owner_d     = OWN_INSTR;
               req_d.addr  = OBI_ADDR_W'(instr_addr_i);
               req_d.we    = 1'b0;
               req_d.be    = '1;
               req_d.wdata = '0;
               tmo_d       = '0;
               state_d     = BUS;
            end
         end
      endcase
   end

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         state_q <= IDLE;
         owner_q <= OWN_INSTR;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   assign instr_gnt_o    = gnt_instr;
   assign data_gnt_o     = gnt_data;
   assign instr_rvalid_o = (state_q == RESP) && (owner_q == OWN_INSTR);
   assign data_rvalid_o  = (state_q == RESP) && (owner_q == OWN_DATA);
   assign instr_rdata_o  = rdata_q;
   assign data_rdata_o   = rdata_q;
   assign instr_err_o    = instr_rvalid_o && err_q;
   assign data_err_o     = data_rvalid_o && err_q;

   assign wb_cyc_o  = (state_q == BUS);
   assign wb_stb_o  = (state_q == BUS);
   assign wb_we_o   = req_q.we;
   assign wb_sel_o  = BE_W'(req_q.be);
   assign wb_addr_o = ADDR_WIDTH'(req_q.addr);
   assign wb_data_o = DATA_WIDTH'(req_q.wdata);

endmodule
